// File: rtl/i2c_pkg.sv
// Shared types for the I2C command sequencer: FSM states, controller
// word bit positions and the queued command layout.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_DONE,
    ST_RESPOND,
    ST_RECOVER
`ifdef I2C_SEQ_RETRY_EN
    , ST_RETRY
`endif
  } state_e;

  localparam int CW_RST_N = 0;
  localparam int CW_START = 1;
  localparam int CW_OP    = 2;
  localparam int CW_DLEN  = 3;
  localparam int CW_SREG  = 4;
  localparam int CW_RLEN  = 5;
  localparam int CW_FRQ   = 6;
  localparam int CW_FCLK  = 8;
  localparam int CW_PADDR = 9;
  localparam int CW_RADDR = 16;

  localparam int SW_RX   = 0;
  localparam int SW_BUSY = 16;
  localparam int SW_NACK = 17;

  localparam int RECOVER_CYCLES = 4;
  localparam int RETRY_GAP      = 16;

  typedef struct packed {
    logic        op;
    logic        data_len;
    logic        send_reg;
    logic        reg_len;
    logic [1:0]  frq_sel;
    logic [6:0]  periph_addr;
    logic [15:0] reg_addr;
    logic [15:0] tx_data;
  } cmd_t;

  function automatic logic [31:0] pack_ctrl(
    input cmd_t c,
    input logic start
  );
    logic [31:0] w;
    w = '0;
    w[CW_RST_N]      = 1'b1;
    w[CW_START]      = start;
    w[CW_OP]         = c.op;
    w[CW_DLEN]       = c.data_len;
    w[CW_SREG]       = c.send_reg;
    w[CW_RLEN]       = c.reg_len;
    w[CW_FRQ+:2]     = c.frq_sel;
    w[CW_FCLK]       = 1'b0;
    w[CW_PADDR+:7]   = c.periph_addr;
    w[CW_RADDR+:16]  = c.reg_addr;
    return w;
  endfunction

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous FIFO for queued commands; DEPTH must be a power of two.
// Push while full is honoured only when a pop happens in the same cycle.
module i2c_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) cnt_d = cnt_q + (AW+1)'(1);
    if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues I2C commands and drives an I2C controller through its control word.
// Define I2C_SEQ_RETRY_EN to re-launch NACKed commands up to MAX_RETRY times.
module i2c_cmd_sequencer
  import i2c_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRY      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic        cmd_data_len,
  input  logic        cmd_send_reg,
  input  logic        cmd_reg_len,
  input  logic [1:0]  cmd_frq_sel,
  input  logic [6:0]  cmd_periph_addr,
  input  logic [15:0] cmd_reg_addr,
  input  logic [15:0] cmd_tx_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rx_data,
  output logic        rsp_nack,
  output logic        rsp_timeout,
  output logic [31:0] ctrl_word,
  output logic [15:0] ctrl_tx,
  input  logic [31:0] stat_word
);

  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_RAW < 5) ? 5 : TW_RAW;
  localparam int CMD_W  = $bits(cmd_t);

  state_e        state_q, state_d;
  cmd_t          act_q, act_d;
  cmd_t          in_cmd, head;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   cw_q, cw_d;
  logic [15:0]   tx_q, tx_d;
  logic [15:0]   rx_q, rx_d;
  logic          nack_q, nack_d;
  logic          tout_q, tout_d;
  logic          pop, full, empty;
  logic          busy, st_nack, tmo_hit;
  logic [CMD_W-1:0] head_raw;
  logic          unused_stat;

`ifdef I2C_SEQ_RETRY_EN
  localparam int RW_RAW = $clog2(MAX_RETRY + 1);
  localparam int RW     = (RW_RAW < 1) ? 1 : RW_RAW;
  logic [RW-1:0] retry_q, retry_d;
`else
  localparam int unused_max_retry = MAX_RETRY;
`endif

  assign in_cmd = '{
    op:          cmd_op,
    data_len:    cmd_data_len,
    send_reg:    cmd_send_reg,
    reg_len:     cmd_reg_len,
    frq_sel:     cmd_frq_sel,
    periph_addr: cmd_periph_addr,
    reg_addr:    cmd_reg_addr,
    tx_data:     cmd_tx_data
  };

  i2c_cmd_fifo #(
    .WIDTH(CMD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (cmd_valid),
    .wr_data(in_cmd),
    .pop    (pop),
    .rd_data(head_raw),
    .full   (full),
    .empty  (empty)
  );

  assign head        = cmd_t'(head_raw);
  assign cmd_ready   = !full;
  assign busy        = stat_word[SW_BUSY];
  assign st_nack     = stat_word[SW_NACK];
  assign tmo_hit     = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign unused_stat = ^stat_word[31:18];

  assign rsp_valid   = (state_q == ST_RESPOND);
  assign rsp_rx_data = rx_q;
  assign rsp_nack    = nack_q;
  assign rsp_timeout = tout_q;
  assign ctrl_word   = cw_q;
  assign ctrl_tx     = tx_q;

  always_comb begin
    state_d        = state_q;
    act_d          = act_q;
    tmo_d          = tmo_q;
    cw_d           = cw_q;
    cw_d[CW_RST_N] = 1'b1;
    tx_d           = tx_q;
    rx_d           = rx_q;
    nack_d         = nack_q;
    tout_d         = tout_q;
    pop            = 1'b0;
`ifdef I2C_SEQ_RETRY_EN
    retry_d        = retry_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          act_d   = head;
          cw_d    = pack_ctrl(head, 1'b1);
          tx_d    = head.tx_data;
          tmo_d   = '0;
          state_d = ST_LAUNCH;
`ifdef I2C_SEQ_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      ST_LAUNCH: begin
        tmo_d = tmo_q + TW'(1);
        cw_d  = pack_ctrl(act_q, 1'b1);
        tx_d  = act_q.tx_data;
        if (busy) begin
          cw_d    = pack_ctrl(act_q, 1'b0);
          state_d = ST_WAIT_DONE;
        end else if (tmo_hit) begin
          cw_d    = pack_ctrl(act_q, 1'b0);
          cw_d[CW_RST_N] = 1'b0;
          tmo_d   = '0;
          state_d = ST_RECOVER;
        end
      end
      ST_WAIT_DONE: begin
        tmo_d = tmo_q + TW'(1);
        if (!busy) begin
          // Writes never return data, whatever the controller leaves behind.
          rx_d    = act_q.op ? stat_word[SW_RX+:16] : 16'h0;
          nack_d  = st_nack;
          tout_d  = 1'b0;
          state_d = ST_RESPOND;
`ifdef I2C_SEQ_RETRY_EN
          if (st_nack && (retry_q < RW'(MAX_RETRY))) begin
            retry_d = retry_q + RW'(1);
            tmo_d   = '0;
            rx_d    = rx_q;
            nack_d  = nack_q;
            tout_d  = tout_q;
            state_d = ST_RETRY;
          end
`endif
        end else if (tmo_hit) begin
          cw_d[CW_RST_N] = 1'b0;
          tmo_d   = '0;
          state_d = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        cw_d[CW_RST_N] = 1'b0;
        tmo_d = tmo_q + TW'(1);
        if (tmo_q == TW'(RECOVER_CYCLES - 1)) begin
          cw_d[CW_RST_N] = 1'b1;
          rx_d    = 16'h0;
          nack_d  = 1'b0;
          tout_d  = 1'b1;
          state_d = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
`ifdef I2C_SEQ_RETRY_EN
      ST_RETRY: begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_q == TW'(RETRY_GAP - 1)) begin
          tmo_d   = '0;
          cw_d    = pack_ctrl(act_q, 1'b1);
          state_d = ST_LAUNCH;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      act_q   <= '0;
      tmo_q   <= '0;
      cw_q    <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      nack_q  <= 1'b0;
      tout_q  <= 1'b0;
`ifdef I2C_SEQ_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      tmo_q   <= tmo_d;
      cw_q    <= cw_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      nack_q  <= nack_d;
      tout_q  <= tout_d;
`ifdef I2C_SEQ_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a behavioural controller stub.
// Expectations follow I2C_SEQ_RETRY_EN when the NACK scenario is checked.
module tb_i2c_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic        cmd_data_len = 1'b0;
  logic        cmd_send_reg = 1'b0;
  logic        cmd_reg_len = 1'b0;
  logic [1:0]  cmd_frq_sel = '0;
  logic [6:0]  cmd_periph_addr = '0;
  logic [15:0] cmd_reg_addr = '0;
  logic [15:0] cmd_tx_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_rx_data;
  logic        rsp_nack;
  logic        rsp_timeout;
  logic [31:0] ctrl_word;
  logic [15:0] ctrl_tx;
  logic [31:0] stat_word = '0;

  int n_cmp = 0;
  int n_bad = 0;

  int          starts = 0;
  int          nack_left = 0;
  bit          hang = 1'b0;
  bit          use_fix = 1'b0;
  logic [15:0] fix_rx = '0;
  int          phase = 0;
  int          dly = 0;
  bit          seen = 1'b0;
  logic [15:0] rxv = '0;

  always #5 clk = ~clk;

  i2c_cmd_sequencer #(
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYCLES(100),
    .MAX_RETRY     (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_data_len   (cmd_data_len),
    .cmd_send_reg   (cmd_send_reg),
    .cmd_reg_len    (cmd_reg_len),
    .cmd_frq_sel    (cmd_frq_sel),
    .cmd_periph_addr(cmd_periph_addr),
    .cmd_reg_addr   (cmd_reg_addr),
    .cmd_tx_data    (cmd_tx_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rx_data    (rsp_rx_data),
    .rsp_nack       (rsp_nack),
    .rsp_timeout    (rsp_timeout),
    .ctrl_word      (ctrl_word),
    .ctrl_tx        (ctrl_tx),
    .stat_word      (stat_word)
  );

  // Controller stub: busy 3 cycles after start, for 20 cycles.
  always @(negedge clk) begin
    if (rst || !ctrl_word[0]) begin
      phase = 0;
      dly = 0;
      seen = 1'b0;
      stat_word = '0;
    end else begin
      if (ctrl_word[1] && !seen) begin
        seen = 1'b1;
        starts++;
        phase = 1;
        dly = 0;
        rxv = use_fix ? fix_rx : ctrl_word[31:16] + 16'h1000;
      end else if (phase == 1) begin
        dly++;
        if (dly == 3 && !hang) begin
          stat_word[16] = 1'b1;
          phase = 2;
          dly = 0;
        end
      end else if (phase == 2) begin
        dly++;
        if (dly == 20) begin
          stat_word[16] = 1'b0;
          stat_word[15:0] = rxv;
          stat_word[17] = (nack_left > 0);
          if (nack_left > 0) nack_left--;
          phase = 0;
        end
      end
      if (!ctrl_word[1]) seen = 1'b0;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic op, input logic dl,
                      input logic sr, input logic rl,
                      input logic [1:0] frq, input logic [6:0] pa,
                      input logic [15:0] ra, input logic [15:0] tx);
    int k;
    k = 0;
    cmd_op = op;
    cmd_data_len = dl;
    cmd_send_reg = sr;
    cmd_reg_len = rl;
    cmd_frq_sel = frq;
    cmd_periph_addr = pa;
    cmd_reg_addr = ra;
    cmd_tx_data = tx;
    cmd_valid = 1'b1;
    while (!cmd_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("push_ready", {31'b0, cmd_ready}, 32'h1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget);
    int k;
    k = 0;
    while (!rsp_valid && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("rsp_seen", {31'b0, rsp_valid}, 32'h1);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_drop", {31'b0, rsp_valid}, 32'h0);
  endtask

  initial begin
    int n;
    int s0;
    bit saw;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl_word", ctrl_word, 32'h0);
    check("rst_ctrl_tx", {16'b0, ctrl_tx}, 32'h0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_rsp_nack", {31'b0, rsp_nack}, 32'h0);
    check("rst_rsp_tmo", {31'b0, rsp_timeout}, 32'h0);
    check("rst_rsp_rx", {16'b0, rsp_rx_data}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_cw", ctrl_word, 32'h1);
    check("post_rst_ready", {31'b0, cmd_ready}, 32'h1);

    // Read from 0x48 reg 0x0010, returns 0xBEEF.
    use_fix = 1'b1;
    fix_rx = 16'hBEEF;
    push(1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 7'h48, 16'h0010, 16'h1234);
    @(posedge clk); #1;
    check("rd_launch_cw", ctrl_word, 32'h0010_90BF);
    check("rd_launch_tx", {16'b0, ctrl_tx}, 32'h1234);
    n = 0;
    while (ctrl_word[1] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("rd_wait_cw", ctrl_word, 32'h0010_90BD);
    wait_rsp(100);
    check("rd_rx", {16'b0, rsp_rx_data}, 32'hBEEF);
    check("rd_nack", {31'b0, rsp_nack}, 32'h0);
    check("rd_tmo", {31'b0, rsp_timeout}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rd_hold_valid", {31'b0, rsp_valid}, 32'h1);
    check("rd_hold_rx", {16'b0, rsp_rx_data}, 32'hBEEF);
    take_rsp();

    // Write: rx forced to zero though stat carries data.
    fix_rx = 16'h5555;
    push(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 7'h21, 16'h00AB, 16'hA5C3);
    @(posedge clk); #1;
    check("wr_launch_cw", ctrl_word, 32'h00AB_4253);
    check("wr_launch_tx", {16'b0, ctrl_tx}, 32'hA5C3);
    wait_rsp(100);
    check("wr_rx_zero", {16'b0, rsp_rx_data}, 32'h0);
    check("wr_nack", {31'b0, rsp_nack}, 32'h0);
    take_rsp();

    // Five back-to-back reads: one active, four queued -> full.
    use_fix = 1'b0;
    for (int i = 1; i <= 5; i++)
      push(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 7'h10, 16'(i), 16'h0);
    check("fifo_full", {31'b0, cmd_ready}, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    check("fifo_still_full", {31'b0, cmd_ready}, 32'h0);
    rsp_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wait_rsp(200);
      check("fifo_order_rx", {16'b0, rsp_rx_data}, 32'h1000 + i);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;

    // Timeout: controller never goes busy.
    hang = 1'b1;
    push(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 7'h33, 16'h0077, 16'h0);
    @(posedge clk); #1;
    check("to_start", {31'b0, ctrl_word[1]}, 32'h1);
    n = 0;
    while (ctrl_word[0] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("to_latency", n, 32'd100);
    n = 0;
    while (!ctrl_word[0] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("to_recover_len", n, 32'd4);
    check("to_valid", {31'b0, rsp_valid}, 32'h1);
    check("to_flag", {31'b0, rsp_timeout}, 32'h1);
    check("to_nack", {31'b0, rsp_nack}, 32'h0);
    check("to_rx", {16'b0, rsp_rx_data}, 32'h0);
    take_rsp();
    hang = 1'b0;

    // NACK twice, then ACK.
    nack_left = 2;
    s0 = starts;
    push(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 7'h50, 16'h0033, 16'h0);
    wait_rsp(600);
`ifdef I2C_SEQ_RETRY_EN
    check("nack_starts", starts - s0, 32'd3);
    check("nack_flag", {31'b0, rsp_nack}, 32'h0);
`else
    check("nack_starts", starts - s0, 32'd1);
    check("nack_flag", {31'b0, rsp_nack}, 32'h1);
`endif
    check("nack_rx", {16'b0, rsp_rx_data}, 32'h1033);
    check("nack_tmo", {31'b0, rsp_timeout}, 32'h0);
    take_rsp();
    nack_left = 0;

    // Reset during WAIT_DONE with a second command still queued.
    push(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 7'h11, 16'h0044, 16'h0);
    push(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 7'h11, 16'h0045, 16'h0);
    n = 0;
    while (!(stat_word[16] && !ctrl_word[1]) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_in_wait", {31'b0, stat_word[16]}, 32'h1);
    rst = 1'b1;
    saw = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_cw0", ctrl_word, 32'h0);
    if (rsp_valid) saw = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_cw1", ctrl_word, 32'h0);
    if (rsp_valid) saw = 1'b1;
    rst = 1'b0;
    s0 = starts;
    repeat (40) begin
      @(posedge clk); #1;
      if (rsp_valid) saw = 1'b1;
    end
    check("mid_no_rsp", {31'b0, saw}, 32'h0);
    check("mid_fifo_empty", starts - s0, 32'd0);
    check("mid_ready", {31'b0, cmd_ready}, 32'h1);
    check("mid_cw_idle", ctrl_word[0], 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
